tank_motion_ctrl: RTL and testbench
===================================

// Module: tank_motion_ctrl
// PURPOSE
//  Parametrised per-player tank controller: keyboard-driven drive/rotate, fixed-point position, wall bump-back,
//  edge-triggered fire with cooldown, and hit/death/round-reset handling. One instance per player, driven from the
//  frame-rate tick. Outputs feed the sprite renderer, the bullet spawner and the sin/cos ROM (via angle).
// PARAMETERS
//  FRAC_BITS    3      fractional bits of internal position (pixel = pos >> FRAC_BITS)
//  POS_W        13     internal position width (unsigned, 10 integer + FRAC_BITS)
//  SPEED        16     drive speed magnitude, 7-bit unsigned
//  ANGLE_STEPS  45     rotation positions per revolution (<=64)
//  BUMP_FRAMES  4      frames of forced reverse motion after wall contact
//  FIRE_CD      16     frames after a shot before the next is accepted
//  SPAWN_X/Y    300/250 spawn pixel; SPAWN_ANG 0
//  KEY_UP/DN/RT/LT/FIRE 8'h52/51/50/4F/2C   USB HID key codes
//  X_MAX/Y_MAX  629/469 max pixel coordinate (screen minus tank size)
// PORTS
//  frame_clk  in   1   frame tick clock
//  Reset      in   1   async, active-high
//  game_end   in   2   nonzero = round over
//  hit        in   1   bullet struck this tank (level, sampled per frame)
//  keycode    in   32  four concurrent HID key bytes
//  wall       in   4   {bottom,top,right,left} contact flags
//  sin, cos   in   8   sign-magnitude Q0.7 of current angle ([7]=sign)
//  tank_x/y   out  10  pixel position;  tank_s out 10 constant 10
//  step_x/y   out  POS_W  signed motion applied this frame (two's complement)
//  angle      out  6   0..ANGLE_STEPS-1
//  shoot      out  1   one-frame fire pulse;  dead out 1  tank destroyed
// BEHAVIOUR
//  Reset (any time, incl. mid-BUMP): state DRIVE, pos=SPAWN<<FRAC_BITS, angle=SPAWN_ANG, steps=0, shoot=0,
//   dead=0, cooldown=0, bump counter=0, fire_prev=0. All outputs registered; key/wall response visible 1 frame later.
//  Motion: mx = (SPEED*cos[6:0])>>7, my = (SPEED*sin[6:0])>>7; forward: x += cos sign ? -mx : +mx,
//   y -= sin sign ? -my : +my (screen y grows down); backward is exact negation. Position wraps never: clamp pixel
//   to [0,X_MAX]/[0,Y_MAX] after update, step outputs report the pre-clamp delta.
//  Key priority among movement: UP > DN > RT > LT; FIRE independent (may fire while moving/rotating).
//  States:
//   DRIVE: wall==0 -> apply key (RT: angle+1, wraps ANGLE_STEPS-1->0; LT: angle-1, 0->ANGLE_STEPS-1).
//     wall!=0 and UP/DN held -> BUMP, latch reverse of attempted step, counter=BUMP_FRAMES. wall!=0 else: no
//     motion, no rotation.
//   BUMP: apply latched step each frame, keys ignored except FIRE, counter-- ; counter hits 0 -> DRIVE.
//   DEAD: entered when hit=1 (priority over wall/keys same frame); dead=1, steps=0, no shoot, frozen.
//   HOLD: entered from any state when game_end!=0 (priority over hit); pos/angle reload spawn, dead=0,
//     cooldown=0; game_end==0 -> DRIVE next frame.
//  Fire: shoot=1 for one frame when FIRE rising edge (fire_prev=0) and cooldown==0 and state in {DRIVE,BUMP};
//   cooldown loads FIRE_CD, decrements to 0 each frame. Held FIRE never repeats.
//  Angle out of range (>=ANGLE_STEPS) is forced to 0 next frame.
// STRUCTURE
//  tank_pkg: state enum {DRIVE,BUMP,DEAD,HOLD}, HID key constants, wall bit indices, tank size constant.
//  Sub-module tank_key_decode: 32-bit keycode + 5 codes -> 5-bit pressed vector (combinational, any byte match).
// TESTING
//  1 Reset, angle 0 (cos=8'h7F,sin=0), hold UP 8 frames -> x pos +15 per frame internal, tank_x 300->315.
//  2 Hold RT from angle 44 -> angle 0 next frame; hold LT from 0 -> 44.
//  3 UP into wall (wall=4'b0010) -> 4 BUMP frames reversing, keys ignored, then DRIVE.
//  4 FIRE held 40 frames -> exactly 1 shoot pulse; taps every 5 frames -> pulses at frame 0 and first tap >=16.
//  5 hit=1 with UP held -> dead=1, position frozen; game_end=2'b01 -> spawn 300/250, dead=0; back to 0 -> drives.
//  6 Reset asserted mid-BUMP and mid-cooldown -> all outputs at reset values same edge; clamp at x=0 moving left.

Source files
------------

// File: rtl/tank_pkg.sv
// tank_pkg: shared controller state, HID key codes, pressed-vector and wall bit indices
package tank_pkg;
  typedef enum logic [1:0] {DRIVE, BUMP, DEAD, HOLD} state_t;
  localparam logic [7:0] HID_UP = 8'h52;
  localparam logic [7:0] HID_DN = 8'h51;
  localparam logic [7:0] HID_RT = 8'h50;
  localparam logic [7:0] HID_LT = 8'h4F;
  localparam logic [7:0] HID_FIRE = 8'h2C;
  localparam int K_UP = 0;
  localparam int K_DN = 1;
  localparam int K_RT = 2;
  localparam int K_LT = 3;
  localparam int K_FIRE = 4;
  localparam int W_LEFT = 0;
  localparam int W_RIGHT = 1;
  localparam int W_TOP = 2;
  localparam int W_BOTTOM = 3;
  localparam logic [9:0] TANK_SIZE = 10'd10;
endpackage

// File: rtl/tank_key_decode.sv
// tank_key_decode: flags each control key present in any of the four HID key bytes
module tank_key_decode
  import tank_pkg::*;
(
  input  logic [31:0] keycode,
  input  logic [7:0]  code_up,
  input  logic [7:0]  code_dn,
  input  logic [7:0]  code_rt,
  input  logic [7:0]  code_lt,
  input  logic [7:0]  code_fire,
  output logic [4:0]  pressed
);
  function automatic logic held(input logic [31:0] kc, input logic [7:0] c);
    return kc[7:0] == c || kc[15:8] == c || kc[23:16] == c || kc[31:24] == c;
  endfunction
  always_comb begin
    pressed = '0;
    pressed[K_UP] = held(keycode, code_up);
    pressed[K_DN] = held(keycode, code_dn);
    pressed[K_RT] = held(keycode, code_rt);
    pressed[K_LT] = held(keycode, code_lt);
    pressed[K_FIRE] = held(keycode, code_fire);
  end
endmodule

// File: rtl/tank_motion_ctrl.sv
// tank_motion_ctrl: per-player tank drive/rotate, wall bump-back, fire cooldown and hit/round handling
module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter int         FRAC_BITS   = 3,
  parameter int         POS_W       = 13,
  parameter logic [6:0] SPEED       = 7'd16,
  parameter int         ANGLE_STEPS = 45,
  parameter int         BUMP_FRAMES = 4,
  parameter int         FIRE_CD     = 16,
  parameter int         SPAWN_X     = 300,
  parameter int         SPAWN_Y     = 250,
  parameter int         SPAWN_ANG   = 0,
  parameter logic [7:0] KEY_UP      = HID_UP,
  parameter logic [7:0] KEY_DN      = HID_DN,
  parameter logic [7:0] KEY_RT      = HID_RT,
  parameter logic [7:0] KEY_LT      = HID_LT,
  parameter logic [7:0] KEY_FIRE    = HID_FIRE,
  parameter int         X_MAX       = 629,
  parameter int         Y_MAX       = 469
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [1:0]       game_end,
  input  logic             hit,
  input  logic [31:0]      keycode,
  input  logic [3:0]       wall,
  input  logic [7:0]       sin,
  input  logic [7:0]       cos,
  output logic [9:0]       tank_x,
  output logic [9:0]       tank_y,
  output logic [9:0]       tank_s,
  output logic [POS_W-1:0] step_x,
  output logic [POS_W-1:0] step_y,
  output logic [5:0]       angle,
  output logic             shoot,
  output logic             dead
);
  localparam int CD_W = $clog2(FIRE_CD + 1);
  localparam int BC_W = $clog2(BUMP_FRAMES + 1);
  localparam int N_W = POS_W + 2;
  localparam logic [POS_W-1:0] HOME_X = POS_W'(SPAWN_X << FRAC_BITS);
  localparam logic [POS_W-1:0] HOME_Y = POS_W'(SPAWN_Y << FRAC_BITS);
  localparam logic [POS_W-1:0] TOP_X = POS_W'(X_MAX << FRAC_BITS);
  localparam logic [POS_W-1:0] TOP_Y = POS_W'(Y_MAX << FRAC_BITS);
  localparam logic signed [N_W-1:0] LIM_X = N_W'((X_MAX + 1) << FRAC_BITS);
  localparam logic signed [N_W-1:0] LIM_Y = N_W'((Y_MAX + 1) << FRAC_BITS);
  localparam logic [5:0] ANG_LAST = 6'(ANGLE_STEPS - 1);
  localparam logic [5:0] ANG_HOME = 6'(SPAWN_ANG);
  state_t state;
  logic [POS_W-1:0] pos_x, pos_y, bump_x, bump_y, fwd_x, fwd_y, mv_x, mv_y, nx_x, nx_y;
  logic [BC_W-1:0] bump_cnt;
  logic [CD_W-1:0] cd;
  logic [6:0] mag_x, mag_y;
  logic [4:0] pressed;
  logic fire_prev, fire_rise, up, dn, rt, lt, turn_ok;
  tank_key_decode u_keys (
    .keycode  (keycode),
    .code_up  (KEY_UP),
    .code_dn  (KEY_DN),
    .code_rt  (KEY_RT),
    .code_lt  (KEY_LT),
    .code_fire(KEY_FIRE),
    .pressed  (pressed)
  );
  // Anything below pixel 0 pins to 0; any pixel past the max pins to the max pixel with zero fraction.
  function automatic logic [POS_W-1:0] clamp(input logic [POS_W-1:0] p, s, top,
                                             input logic signed [N_W-1:0] lim);
    logic signed [N_W-1:0] n;
    n = $signed({2'b00, p}) + $signed({{2{s[POS_W-1]}}, s});
    return n[N_W-1] ? '0 : (n >= lim) ? top : n[POS_W-1:0];
  endfunction
  always_comb begin
    mag_x = 7'(({7'd0, SPEED} * {7'd0, cos[6:0]}) >> 7);
    mag_y = 7'(({7'd0, SPEED} * {7'd0, sin[6:0]}) >> 7);
    fwd_x = cos[7] ? -POS_W'(mag_x) : POS_W'(mag_x);
    fwd_y = sin[7] ? POS_W'(mag_y) : -POS_W'(mag_y);
    up = pressed[K_UP];
    dn = pressed[K_DN] & ~up;
    rt = pressed[K_RT] & ~pressed[K_UP] & ~pressed[K_DN];
    lt = pressed[K_LT] & ~pressed[K_RT] & ~pressed[K_UP] & ~pressed[K_DN];
    mv_x = up ? fwd_x : dn ? -fwd_x : '0;
    mv_y = up ? fwd_y : dn ? -fwd_y : '0;
    turn_ok = state == DRIVE && wall == '0;
    nx_x = state == BUMP ? bump_x : turn_ok ? mv_x : '0;
    nx_y = state == BUMP ? bump_y : turn_ok ? mv_y : '0;
    fire_rise = pressed[K_FIRE] & ~fire_prev;
  end
  assign tank_x = pos_x[POS_W-1:FRAC_BITS];
  assign tank_y = pos_y[POS_W-1:FRAC_BITS];
  assign tank_s = TANK_SIZE;
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= DRIVE;
      pos_x <= HOME_X;
      pos_y <= HOME_Y;
      angle <= ANG_HOME;
      step_x <= '0;
      step_y <= '0;
      bump_x <= '0;
      bump_y <= '0;
      bump_cnt <= '0;
      cd <= '0;
      fire_prev <= 1'b0;
      shoot <= 1'b0;
      dead <= 1'b0;
    end else begin
      fire_prev <= pressed[K_FIRE];
      shoot <= 1'b0;
      step_x <= '0;
      step_y <= '0;
      cd <= cd == '0 ? cd : cd - CD_W'(1);
      if (game_end != 2'b00) begin
        state <= HOLD;
        pos_x <= HOME_X;
        pos_y <= HOME_Y;
        angle <= ANG_HOME;
        dead <= 1'b0;
        cd <= '0;
      end else if (state == HOLD) begin
        state <= DRIVE;
      end else if (hit || state == DEAD) begin
        state <= DEAD;
        dead <= 1'b1;
      end else begin
        pos_x <= clamp(pos_x, nx_x, TOP_X, LIM_X);
        pos_y <= clamp(pos_y, nx_y, TOP_Y, LIM_Y);
        step_x <= nx_x;
        step_y <= nx_y;
        if (fire_rise && cd == '0) begin
          shoot <= 1'b1;
          cd <= CD_W'(FIRE_CD);
        end
        if ({1'b0, angle} >= 7'(ANGLE_STEPS))
          angle <= '0;
        else if (turn_ok && rt)
          angle <= angle == ANG_LAST ? '0 : angle + 6'd1;
        else if (turn_ok && lt)
          angle <= angle == '0 ? ANG_LAST : angle - 6'd1;
        // Wall contact while driving latches the reverse of the attempted step for the bump-back.
        if (state == BUMP) begin
          bump_cnt <= bump_cnt - BC_W'(1);
          if (bump_cnt <= BC_W'(1)) state <= DRIVE;
        end else if (wall != '0 && (up || dn)) begin
          state <= BUMP;
          bump_x <= -mv_x;
          bump_y <= -mv_y;
          bump_cnt <= BC_W'(BUMP_FRAMES);
        end
      end
    end
  end
endmodule

// File: tb/tb_tank_motion_ctrl.sv
// tb_tank_motion_ctrl: directed scenarios plus randomized frames checked against a behavioural tank model
module tb_tank_motion_ctrl;
  logic frame_clk = 1'b0;
  logic Reset;
  logic [1:0] game_end = '0;
  logic hit = 1'b0;
  logic [31:0] keycode = '0;
  logic [3:0] wall = '0;
  logic [7:0] sin = '0, cos = 8'h7F;
  logic [9:0] tank_x, tank_y, tank_s;
  logic [12:0] step_x, step_y;
  logic [5:0] angle;
  logic shoot, dead;

  tank_motion_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .game_end(game_end), .hit(hit), .keycode(keycode),
    .wall(wall), .sin(sin), .cos(cos), .tank_x(tank_x), .tank_y(tank_y), .tank_s(tank_s),
    .step_x(step_x), .step_y(step_y), .angle(angle), .shoot(shoot), .dead(dead)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int m_px, m_py, m_ang, m_sx, m_sy, m_cd, m_bump, m_bx, m_by;
  bit m_shoot, m_dead, m_hold, m_fprev;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit has(logic [31:0] kc, logic [7:0] c);
    for (int i = 0; i < 4; i++) if (kc[8*i +: 8] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int clampv(int v, int maxpix);
    if (v < 0) return 0;
    if (v / 8 > maxpix) return maxpix * 8;
    return v;
  endfunction

  task automatic m_reset();
    m_px = 2400; m_py = 2000; m_ang = 0; m_sx = 0; m_sy = 0; m_cd = 0;
    m_bump = 0; m_bx = 0; m_by = 0; m_shoot = 0; m_dead = 0; m_hold = 0; m_fprev = 0;
  endtask

  // One frame of the game rules, applied to the inputs the DUT just sampled.
  task automatic m_step();
    bit up, dn, rt, lt, rise;
    int mx, my, dx, dy, old_cd;
    up = has(keycode, 8'h52);
    dn = !up && has(keycode, 8'h51);
    rt = !up && !dn && has(keycode, 8'h50);
    lt = !up && !dn && !rt && has(keycode, 8'h4F);
    rise = has(keycode, 8'h2C) && !m_fprev;
    m_fprev = has(keycode, 8'h2C);
    m_shoot = 0; m_sx = 0; m_sy = 0;
    old_cd = m_cd;
    if (m_cd > 0) m_cd--;
    if (game_end != 0) begin
      m_hold = 1; m_dead = 0; m_bump = 0; m_px = 2400; m_py = 2000; m_ang = 0; m_cd = 0;
    end else if (m_hold) m_hold = 0;
    else if (hit || m_dead) m_dead = 1;
    else begin
      mx = 16 * int'(cos[6:0]) / 128;
      my = 16 * int'(sin[6:0]) / 128;
      dx = cos[7] ? -mx : mx;
      dy = sin[7] ? my : -my;
      if (m_bump > 0) begin
        m_sx = m_bx; m_sy = m_by; m_bump--;
      end else if (wall != 0) begin
        if (up || dn) begin
          m_bump = 4; m_bx = up ? -dx : dx; m_by = up ? -dy : dy;
        end
      end else begin
        m_sx = up ? dx : dn ? -dx : 0;
        m_sy = up ? dy : dn ? -dy : 0;
        if (rt) m_ang = (m_ang + 1) % 45;
        else if (lt) m_ang = (m_ang + 44) % 45;
      end
      m_px = clampv(m_px + m_sx, 629);
      m_py = clampv(m_py + m_sy, 469);
      if (rise && old_cd == 0) begin
        m_shoot = 1; m_cd = 16;
      end
    end
  endtask

  task automatic frame();
    @(posedge frame_clk);
    #1 m_step();
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1 m_reset();
  endtask

  function automatic logic [7:0] rk();
    case ($urandom_range(0, 7))
      0: return 8'h52;
      1: return 8'h51;
      2: return 8'h50;
      3: return 8'h4F;
      4: return 8'h2C;
      7: return 8'($urandom_range(0, 255));
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge frame_clk) begin
    if (chk_en) begin
      check("tank_x", tank_x, m_px / 8);
      check("tank_y", tank_y, m_py / 8);
      check("step_x", $signed(step_x), m_sx);
      check("step_y", $signed(step_y), m_sy);
      check("angle", angle, m_ang);
      check("shoot", shoot, m_shoot);
      check("dead", dead, m_dead);
      check("tank_s", tank_s, 10);
    end
  end

  initial begin
    int pulses, last, x0;
    Reset = 1'b1;
    m_reset();
    chk_en = 1;
    #6;
    check("rst_x", tank_x, 300);
    check("rst_y", tank_y, 250);
    check("rst_ang", angle, 0);
    #1 Reset = 1'b0;
    // drive forward at angle 0
    keycode = 32'h52;
    repeat (8) frame();
    check("t1_x", tank_x, 315);
    check("t1_model_x", m_px, 2520);
    check("t1_step", $signed(step_x), 15);
    check("t1_y", tank_y, 250);
    // rotation wrap both ways
    keycode = 32'h4F;
    frame();
    check("t2_lt_wrap", angle, 44);
    keycode = 32'h50;
    frame();
    check("t2_rt_wrap", angle, 0);
    // drive into the right wall, then bump back with keys ignored
    keycode = 32'h52;
    wall = 4'b0010;
    frame();
    check("t3_enter", $signed(step_x), 0);
    wall = 4'b0000;
    keycode = 32'h50;
    for (int i = 0; i < 4; i++) begin
      frame();
      check("t3_bump", $signed(step_x), -15);
      check("t3_noturn", angle, 0);
    end
    keycode = 32'h52;
    frame();
    check("t3_drive", $signed(step_x), 15);
    // held fire fires once; taps every 5 frames respect cooldown
    keycode = 32'h2C;
    pulses = 0;
    repeat (40) begin
      frame();
      pulses += int'(shoot);
    end
    check("t4_held", pulses, 1);
    keycode = 32'h0;
    frame();
    pulses = 0;
    last = -1;
    for (int i = 0; i < 25; i++) begin
      keycode = (i % 5 == 0) ? 32'h2C : 32'h0;
      frame();
      if (shoot) begin
        pulses++;
        last = i;
      end
    end
    check("t4_taps", pulses, 2);
    check("t4_last_tap", last, 20);
    // hit, death freeze, round reset
    keycode = 32'h52;
    hit = 1'b1;
    x0 = tank_x;
    frame();
    check("t5_dead", dead, 1);
    check("t5_frozen", tank_x, x0);
    hit = 1'b0;
    frame();
    check("t5_still_dead", dead, 1);
    check("t5_still_frozen", tank_x, x0);
    game_end = 2'b01;
    frame();
    check("t5_spawn_x", tank_x, 300);
    check("t5_spawn_y", tank_y, 250);
    check("t5_alive", dead, 0);
    game_end = 2'b00;
    frame();
    check("t5_hold_exit", tank_x, 300);
    repeat (4) frame();
    check("t5_drives", tank_x, 307);
    // reset mid-bump and mid-cooldown
    keycode = 32'h2C52;
    wall = 4'b0010;
    frame();
    check("t6_shot", shoot, 1);
    wall = 4'b0000;
    frame();
    check("t6_bumping", $signed(step_x), -15);
    pulse_reset();
    check("t6_rst_step", $signed(step_x), 0);
    check("t6_rst_x", tank_x, 300);
    check("t6_rst_shoot", shoot, 0);
    check("t6_rst_ang", angle, 0);
    #1 Reset = 1'b0;
    frame();
    check("t6_cd_clear", shoot, 1);
    check("t6_no_bump", $signed(step_x), 15);
    // clamp at the left edge
    keycode = 32'h52;
    cos = 8'hFF;
    repeat (170) frame();
    check("t6_clamp_x", tank_x, 0);
    check("t6_clamp_model", m_px, 0);
    check("t6_clamp_step", $signed(step_x), -15);
    // randomized frames
    repeat (2500) begin
      game_end = ($urandom_range(0, 99) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
      hit = $urandom_range(0, 39) == 0;
      wall = ($urandom_range(0, 99) < 20) ? 4'($urandom_range(1, 15)) : 4'b0000;
      keycode = {rk(), rk(), rk(), rk()};
      sin = 8'($urandom_range(0, 255));
      cos = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
        #1 Reset = 1'b0;
      end
      frame();
    end
    @(negedge frame_clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
